// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the iterative divider sequencer: bus widths,
// state encodings, handshake constants and the divide aluop codes.
package div_sequencer_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic RstEnable = 1'b1;

  // State encodings
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Request / result handshake levels
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Aluop codes that route an instruction to this unit
  localparam logic [7:0] DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    ST_IDLE   = DivFree,
    ST_BYZERO = DivByZero,
    ST_RUN    = DivOn,
    ST_DONE   = DivEnd
  } div_state_e;

  // Two's-complement magnitude for signed operands, raw value otherwise.
  function automatic logic [RegBus-1:0] magnitude(input logic sg,
                                                  input logic [RegBus-1:0] v);
    return (sg && v[RegBus-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_sequencer.sv
// div_sequencer: 32-step restoring divider controller for DIV/DIVU.
// Returns {remainder, quotient} and requests a pipeline stall while busy.
// Build option DIV_BYZERO_FAST_EN: a zero divisor completes in one clock
// with a zero result instead of iterating through RUN.
//
// Handshake: execute holds start_in high until it has consumed the result;
// ready_out rises once the result is valid and stays high until start_in
// drops, at which point result_out clears and the unit returns to IDLE.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_in,
  input  logic [RegBus-1:0]       src1_data_in,
  input  logic [RegBus-1:0]       src2_data_in,
  input  logic                    start_in,
  input  logic                    annul_in,
  output logic [DoubleRegBus-1:0] result_out,
  output logic                    ready_out,
  output logic                    stall_req_out
);

  div_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [64:0]             partial_q, partial_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    dvd_neg_q, dvd_neg_d;
  logic                    dvs_neg_q, dvs_neg_d;
  logic                    signed_q, signed_d;
  logic [DoubleRegBus-1:0] result_d;
  logic                    ready_d;

  logic [32:0]       diff;
  logic [RegBus-1:0] quot;
  logic [RegBus-1:0] rem;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  assign stall_req_out = start_in & ~ready_out;

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      partial_q  <= '0;
      divisor_q  <= '0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      signed_q   <= 1'b0;
      result_out <= '0;
      ready_out  <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      partial_q  <= partial_d;
      divisor_q  <= divisor_d;
      dvd_neg_q  <= dvd_neg_d;
      dvs_neg_q  <= dvs_neg_d;
      signed_q   <= signed_d;
      result_out <= result_d;
      ready_out  <= ready_d;
    end
  end

  // Next-state, iteration step and sign fixup.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    partial_d = partial_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    signed_d  = signed_q;
    result_d  = result_out;
    ready_d   = ready_out;

    // Trial subtraction of the divisor from the upper partial remainder.
    diff = {1'b0, partial_q[63:32]} - {1'b0, divisor_q};

    quot     = partial_q[31:0];
    rem      = partial_q[64:33];
    quot_fix = (signed_q && (dvd_neg_q ^ dvs_neg_q)) ? (32'd0 - quot) : quot;
    rem_fix  = (signed_q && dvd_neg_q) ? (32'd0 - rem) : rem;

    case (state_q)
      ST_IDLE: begin
        if (start_in == DivStart && !annul_in) begin
`ifdef DIV_BYZERO_FAST_EN
          if (src2_data_in == '0) begin
            state_d = ST_BYZERO;
          end else
`endif
          begin
            divisor_d = magnitude(signed_div_in, src2_data_in);
            partial_d = {32'b0, magnitude(signed_div_in, src1_data_in), 1'b0};
            dvd_neg_d = src1_data_in[RegBus-1];
            dvs_neg_d = src2_data_in[RegBus-1];
            signed_d  = signed_div_in;
            cnt_d     = '0;
            state_d   = ST_RUN;
          end
        end
      end

`ifdef DIV_BYZERO_FAST_EN
      ST_BYZERO: begin
        if (annul_in) begin
          state_d = ST_IDLE;
        end else begin
          result_d = '0;
          ready_d  = DivResultReady;
          state_d  = ST_DONE;
        end
      end
`endif

      ST_RUN: begin
        if (annul_in) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 6'd32) begin
          if (diff[32]) begin
            partial_d = {partial_q[63:0], 1'b0};
          end else begin
            partial_d = {diff[31:0], partial_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        if (start_in == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: a cycle-level reference model with an expected
// result queue is compared against the DUT every cycle; directed divides
// also pin results and latencies to hand-computed literals.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        start;
  logic        annul;
  logic [63:0] result_out;
  logic        ready_out;
  logic        stall_req_out;

`ifdef DIV_BYZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Clock / reset
  always #5 clk = ~clk;

  div_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .signed_div_in (signed_div),
    .src1_data_in  (src1),
    .src2_data_in  (src2),
    .start_in      (start),
    .annul_in      (annul),
    .result_out    (result_out),
    .ready_out     (ready_out),
    .stall_req_out (stall_req_out)
  );

  // Reference arithmetic: {remainder, quotient} from plain division.
  function automatic logic [63:0] ref_div(bit sg, logic [31:0] a, logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) begin
      if (FAST) return 64'd0;
      if (sg && a[31]) return {a, 32'h0000_0001};
      return {a, 32'hFFFF_FFFF};
    end
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(logic [31:0] b);
    return (FAST && b == 32'd0) ? 1 : 33;
  endfunction

  // Scoreboard model: idle / busy (countdown) / result-held.
  logic [63:0] exp_q[$];
  bit          m_busy;
  int          m_rem;
  bit          m_ready;
  logic [63:0] m_result;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_rem = 0; m_ready = 0; m_result = '0;
      exp_q.delete();
    end else if (m_ready) begin
      if (!start) begin m_ready = 0; m_result = '0; end
    end else if (m_busy) begin
      if (annul) begin
        m_busy = 0;
        exp_q.delete();
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_ready = 1;
          m_result = exp_q.pop_front();
        end
      end
    end else if (start && !annul) begin
      m_busy = 1;
      m_rem = ref_lat(src2);
      exp_q.push_back(ref_div(signed_div, src1, src2));
    end
  end

  task automatic check64(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check64("ready_out", {63'd0, ready_out}, {63'd0, m_ready});
      check64("result_out", result_out, m_result);
      check64("stall_req_out", {63'd0, stall_req_out}, {63'd0, start & ~m_ready});
    end
  end

  // Driver: one full divide with literal result and latency expectations.
  task automatic go_div(string nm, bit sg, logic [31:0] a, logic [31:0] b,
                        logic [63:0] exp, int exp_lat);
    int n, st;
    bit seen;
    signed_div = sg; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    // Operands are don't-care once accepted.
    src1 = 32'hDEAD_BEEF; src2 = 32'h0; signed_div = ~sg;
    n = 0; st = 0; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (stall_req_out) st++;
      @(posedge clk); #1;
      n++;
      if (ready_out) seen = 1;
    end
    check_int({nm, "_ready_seen"}, int'(seen), 1);
    check_int({nm, "_latency"}, n, exp_lat);
    check_int({nm, "_stall_cycles"}, st, exp_lat);
    check64({nm, "_result"}, result_out, exp);
    // Held while start stays high.
    @(posedge clk); #1;
    check64({nm, "_hold"}, result_out, exp);
    start = 1'b0;
    @(posedge clk); #1;
    check_int({nm, "_exit_ready"}, int'(ready_out), 0);
  endtask

  initial begin
    int ones;
    bit ever;
    rst = 1'b1; signed_div = 0; src1 = '0; src2 = '0; start = 0; annul = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check64("reset_result", result_out, 64'd0);
    check_int("reset_ready", int'(ready_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    go_div("u100_7", 0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    go_div("s_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    go_div("s_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
    go_div("s_min_m1", 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
    go_div("u_max_1", 0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 33);
    if (FAST) go_div("u5_0", 0, 32'd5, 32'd0, 64'd0, 1);
    else      go_div("u5_0", 0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 33);

    // Annul after 10 iterations: nothing must complete.
    signed_div = 0; src1 = 32'd1000; src2 = 32'd3; start = 1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1;
    @(posedge clk); #1;
    annul = 0; start = 0;
    ever = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_out) ever = 1;
    end
    check_int("annul_no_ready", int'(ever), 0);
    go_div("u9_3", 0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // start drops mid-RUN: divide completes, ready for a single cycle.
    signed_div = 0; src1 = 32'd50; src2 = 32'd5; start = 1;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    start = 0;
    ones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_out) ones++;
    end
    check_int("early_drop_ready_cycles", ones, 1);

    // Reset mid-RUN.
    signed_div = 0; src1 = 32'd100; src2 = 32'd7; start = 1;
    @(posedge clk); #1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    check_int("rst_run_ready", int'(ready_out), 0);
    check64("rst_run_result", result_out, 64'd0);
    rst = 0; start = 0;
    @(posedge clk); #1;

    // Reset while in DONE.
    signed_div = 0; src1 = 32'd100; src2 = 32'd7; start = 1;
    ever = 0;
    for (int k = 0; k < 100 && !ever; k++) begin
      @(posedge clk); #1;
      if (ready_out) ever = 1;
    end
    check_int("rst_done_reached", int'(ever), 1);
    rst = 1;
    @(posedge clk); #1;
    check_int("rst_done_ready", int'(ready_out), 0);
    check64("rst_done_result", result_out, 64'd0);
    rst = 0; start = 0;
    @(posedge clk); #1;

    go_div("u1000_10", 0, 32'd1000, 32'd10, 64'h00000000_00000064, 33);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
